intr_ctrl: RTL and testbench

- Priority interrupt controller between the external intr[7:0] lines and the cpu control unit.
- Captures rising edges into a pending register and applies a per-line mask.
- Arbitrates by fixed priority with nesting (line 0 highest), requests the cpu, and returns the handler vector on acknowledge.
- Tracks in-service lines until the cpu signals end-of-interrupt (reti).

---
 rtl/intr_ctrl.sv | 133 +++++++++++++
 tb/tb_intr_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Fixed-priority nesting interrupt controller: captures rising edges on intr,
// masks them, requests the cpu and returns the winning line's handler vector.
module intr_ctrl #(
   parameter int                N_INT      = 8,
   parameter int                ADDR_W     = 10,
   parameter logic [ADDR_W-1:0] VEC_BASE   = 10'h3C0,
   parameter int                VEC_STRIDE = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_INT-1:0]  intr,
   input  logic              mask_we,
   input  logic [N_INT-1:0]  mask_in,
   input  logic              int_ack,
   input  logic              eoi,
   output logic              irq,
   output logic [ADDR_W-1:0] vector,
   output logic              vec_valid,
   output logic [N_INT-1:0]  pending,
   output logic [N_INT-1:0]  in_service,
   output logic [N_INT-1:0]  mask_out,
   output logic              dbg_state
);

   localparam int IDX_W = $clog2(N_INT + 1);

   // Handshake: irq stays high while a line is eligible and is consumed by a
   // one-cycle int_ack; the vector is then reported by a one-cycle vec_valid
   // strobe with no back-pressure. eoi is a one-cycle pulse per handler exit.
   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [N_INT-1:0]    intr_q, intr_d;
   logic [N_INT-1:0]    pending_q, pending_d;
   logic [N_INT-1:0]    in_service_q, in_service_d;
   logic [N_INT-1:0]    mask_q, mask_d;
   logic                irq_q, irq_d;
   logic [ADDR_W-1:0]   vector_q, vector_d;
   logic                vec_valid_q, vec_valid_d;

   logic [N_INT-1:0]    rise;
   logic [N_INT-1:0]    eoi_clr;
   logic [N_INT-1:0]    below;
   logic [N_INT-1:0]    eligible;
   logic [N_INT-1:0]    win_oh;
   logic [N_INT-1:0]    ack_set;
   logic [IDX_W-1:0]    ceiling;
   logic [IDX_W-1:0]    winner;
   logic                any_elig;
   logic                ack_take;

   always_comb begin
      rise    = intr & ~intr_q;
      eoi_clr = eoi ? (in_service_q & (~in_service_q + N_INT'(1))) : '0;

      ceiling = IDX_W'(N_INT);
      for (int i = N_INT - 1; i >= 0; i--) begin
         if (in_service_q[i]) ceiling = IDX_W'(i);
      end
      for (int i = 0; i < N_INT; i++) begin
         below[i] = (IDX_W'(i) < ceiling);
      end

      eligible = pending_q & ~mask_q & below;
      any_elig = |eligible;
      win_oh   = eligible & (~eligible + N_INT'(1));
      winner   = '0;
      for (int i = 0; i < N_INT; i++) begin
         if (win_oh[i]) winner = IDX_W'(i);
      end

      // The winner is re-evaluated every cycle so a later higher-priority
      // arrival still wins if it shows up before the acknowledge.
      ack_take = (state_q == REQ) && int_ack && any_elig;
      ack_set  = ack_take ? win_oh : '0;

      intr_d       = intr;
      pending_d    = (pending_q & ~ack_set) | rise;
      in_service_d = (in_service_q & ~eoi_clr) | ack_set;
      mask_d       = mask_we ? mask_in : mask_q;

      state_d     = state_q;
      vector_d    = vector_q;
      vec_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_elig) state_d = REQ;
         end
         REQ: begin
            if (!any_elig) begin
               state_d = IDLE;
            end else if (int_ack) begin
               state_d     = IDLE;
               vector_d    = VEC_BASE + ADDR_W'(VEC_STRIDE) * ADDR_W'(winner);
               vec_valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      irq_d = (state_d == REQ);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         intr_q       <= '0;
         pending_q    <= '0;
         in_service_q <= '0;
         mask_q       <= '0;
         irq_q        <= 1'b0;
         vector_q     <= '0;
         vec_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         intr_q       <= intr_d;
         pending_q    <= pending_d;
         in_service_q <= in_service_d;
         mask_q       <= mask_d;
         irq_q        <= irq_d;
         vector_q     <= vector_d;
         vec_valid_q  <= vec_valid_d;
      end
   end

   assign irq        = irq_q;
   assign vector     = vector_q;
   assign vec_valid  = vec_valid_q;
   assign pending    = pending_q;
   assign in_service = in_service_q;
   assign mask_out   = mask_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios plus random traffic, all checked
// against a priority/nesting reference model and a vector scoreboard.
module tb_intr_ctrl;

   logic       clk;
   logic       reset;
   logic [7:0] intr;
   logic       mask_we;
   logic [7:0] mask_in;
   logic       int_ack;
   logic       eoi;
   logic       irq;
   logic [9:0] vector;
   logic       vec_valid;
   logic [7:0] pending;
   logic [7:0] in_service;
   logic [7:0] mask_out;
   logic       dbg_state;

   intr_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .intr       (intr),
      .mask_we    (mask_we),
      .mask_in    (mask_in),
      .int_ack    (int_ack),
      .eoi        (eoi),
      .irq        (irq),
      .vector     (vector),
      .vec_valid  (vec_valid),
      .pending    (pending),
      .in_service (in_service),
      .mask_out   (mask_out),
      .dbg_state  (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
      n_checks++;
      if (obs_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs_v, exp_v, $time);
      end
   endtask

   // reference model: lines as plain bit vectors walked by index
   logic [7:0] m_prev, m_pend, m_insvc, m_mask;
   logic [9:0] m_vec;
   bit         m_req, m_vv;
   logic [9:0] exp_q[$];

   task automatic model_reset();
      m_prev = '0; m_pend = '0; m_insvc = '0; m_mask = '0;
      m_vec = '0; m_req = 0; m_vv = 0;
      exp_q.delete();
   endtask

   task automatic model_step();
      int ceil_i;
      int win;
      int eoi_i;
      logic [7:0] new_pend;
      logic [7:0] new_insvc;
      ceil_i = 8;
      for (int i = 7; i >= 0; i--) if (m_insvc[i]) ceil_i = i;
      win = -1;
      for (int i = 0; i < ceil_i; i++) if (win < 0 && m_pend[i] && !m_mask[i]) win = i;
      eoi_i = -1;
      if (eoi) for (int i = 7; i >= 0; i--) if (m_insvc[i]) eoi_i = i;
      new_pend  = m_pend;
      new_insvc = m_insvc;
      if (eoi_i >= 0) new_insvc[eoi_i] = 1'b0;
      m_vv = 0;
      if (m_req) begin
         if (win < 0) begin
            m_req = 0;
         end else if (int_ack) begin
            new_pend[win]  = 1'b0;
            new_insvc[win] = 1'b1;
            m_vec = 10'(960 + win * 4);
            m_vv  = 1;
            m_req = 0;
            exp_q.push_back(m_vec);
         end
      end else if (win >= 0) begin
         m_req = 1;
      end
      m_pend  = new_pend | (intr & ~m_prev);
      m_insvc = new_insvc;
      if (mask_we) m_mask = mask_in;
      m_prev = intr;
   endtask

   task automatic compare_all();
      check("irq", 32'(irq), 32'(m_req));
      check("vec_valid", 32'(vec_valid), 32'(m_vv));
      check("vector", 32'(vector), 32'(m_vec));
      check("pending", 32'(pending), 32'(m_pend));
      check("in_service", 32'(in_service), 32'(m_insvc));
      check("mask_out", 32'(mask_out), 32'(m_mask));
      if (vec_valid) begin
         if (exp_q.size() == 0) check("sb_unexpected_vector", 32'(vector), 32'h3ff_ffff);
         else check("sb_vector", 32'(vector), 32'(exp_q.pop_front()));
      end
   endtask

   // driver: apply inputs for one clock, advance the model, sample #1 later
   task automatic step(input logic [7:0] i_v, input logic we, input logic [7:0] m_v,
                       input logic ack, input logic e);
      intr = i_v; mask_we = we; mask_in = m_v; int_ack = ack; eoi = e;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   int         n_vv;
   bit         seen;
   logic [7:0] cur_intr;

   initial begin
      reset = 1'b0; intr = '0; mask_we = 0; mask_in = '0; int_ack = 0; eoi = 0;
      model_reset();
      #12;
      check("rst_irq", 32'(irq), 0);
      check("rst_vector", 32'(vector), 0);
      check("rst_pending", 32'(pending), 0);
      check("rst_mask", 32'(mask_out), 0);
      @(negedge clk); reset = 1'b1;

      // basic request / ack / eoi
      step(8'h11, 0, 0, 0, 0);
      check("t1_pend", 32'(pending), 32'h11);
      step(8'h00, 0, 0, 0, 0);
      check("t1_irq", 32'(irq), 1);
      step(8'h00, 0, 0, 1, 0);
      check("t1_vec0", 32'(vector), 32'h3C0);
      check("t1_vv", 32'(vec_valid), 1);
      check("t1_isr", 32'(in_service), 32'h01);
      check("t1_pend2", 32'(pending), 32'h10);
      step(8'h00, 0, 0, 0, 0);
      check("t1_irq_low", 32'(irq), 0);
      step(8'h00, 0, 0, 0, 1);
      check("t1_isr_clr", 32'(in_service), 0);
      step(8'h00, 0, 0, 0, 0);
      check("t1_irq_again", 32'(irq), 1);
      step(8'h00, 0, 0, 1, 0);
      check("t1_vec4", 32'(vector), 32'h3D0);
      check("t1_isr4", 32'(in_service), 32'h10);

      // nesting under line 4
      step(8'hA2, 0, 0, 0, 0);
      step(8'h00, 0, 0, 0, 0);
      check("t2_irq", 32'(irq), 1);
      step(8'h00, 0, 0, 1, 0);
      check("t2_vec1", 32'(vector), 32'h3C4);
      check("t2_isr", 32'(in_service), 32'h12);
      step(8'h00, 0, 0, 0, 1);
      check("t2_isr_eoi", 32'(in_service), 32'h10);
      step(8'h00, 0, 0, 0, 0);
      check("t2_blocked", 32'(irq), 0);
      step(8'h00, 0, 0, 0, 1);
      step(8'h00, 0, 0, 0, 0);
      step(8'h00, 0, 0, 1, 0);
      check("t2_vec5", 32'(vector), 32'h3D4);
      step(8'h00, 0, 0, 0, 1);
      step(8'h00, 0, 0, 0, 0);
      step(8'h00, 0, 0, 1, 0);
      check("t2_vec7", 32'(vector), 32'h3DC);
      step(8'h00, 0, 0, 0, 1);

      // masking
      step(8'h00, 1, 8'hFF, 0, 0);
      step(8'h08, 0, 0, 0, 0);
      check("t3_pend", 32'(pending), 32'h08);
      for (int k = 0; k < 10; k++) step(8'h00, 0, 0, 0, 0);
      check("t3_masked", 32'(irq), 0);
      step(8'h00, 1, 8'h00, 0, 0);
      seen = 0;
      for (int k = 0; k < 2 && !seen; k++) begin
         step(8'h00, 0, 0, 0, 0);
         seen = irq;
      end
      check("t3_irq_within_2", 32'(seen), 1);
      step(8'h00, 0, 0, 1, 0);
      check("t3_vec3", 32'(vector), 32'h3CC);
      step(8'h00, 0, 0, 0, 1);

      // ack colliding with a fresh edge on the same line
      step(8'h04, 0, 0, 0, 0);
      step(8'h00, 0, 0, 0, 0);
      step(8'h04, 0, 0, 1, 0);
      check("t4_pend2", 32'(pending[2]), 1);
      check("t4_isr2", 32'(in_service[2]), 1);
      step(8'h04, 0, 0, 0, 1);
      step(8'h04, 0, 0, 0, 0);
      step(8'h04, 0, 0, 1, 0);
      check("t4_vec2", 32'(vector), 32'h3C8);
      step(8'h00, 0, 0, 0, 1);
      // ack and eoi together
      step(8'h02, 0, 0, 0, 0);
      step(8'h00, 0, 0, 0, 0);
      step(8'h00, 0, 0, 1, 0);
      step(8'h01, 0, 0, 0, 0);
      step(8'h00, 0, 0, 0, 0);
      step(8'h00, 0, 0, 1, 1);
      check("t4_ack_eoi_isr", 32'(in_service), 32'h01);
      step(8'h00, 0, 0, 0, 1);

      // level held high, spurious ack / eoi
      n_vv = 0;
      for (int k = 0; k < 10; k++) begin
         step(8'h40, 0, 0, (k == 2), 0);
         if (vec_valid) n_vv++;
      end
      check("t5_one_vector", 32'(n_vv), 1);
      check("t5_vec6", 32'(vector), 32'h3D8);
      check("t5_no_repend", 32'(pending), 0);
      step(8'h00, 0, 0, 0, 1);
      step(8'h00, 0, 0, 1, 0);
      check("t5_idle_ack", 32'(vec_valid), 0);
      step(8'h00, 0, 0, 0, 1);
      check("t5_eoi_empty", 32'(in_service), 0);

      // async reset while requesting with lines in service
      step(8'h04, 0, 0, 0, 0);
      step(8'h00, 0, 0, 0, 0);
      step(8'h00, 0, 0, 1, 0);
      step(8'h02, 0, 0, 0, 0);
      step(8'h00, 0, 0, 0, 0);
      step(8'h00, 0, 0, 1, 0);
      step(8'h01, 1, 8'h80, 0, 0);
      step(8'h00, 0, 0, 0, 0);
      check("t6_pre_irq", 32'(irq), 1);
      check("t6_pre_isr", 32'(in_service), 32'h06);
      #2 reset = 1'b0;
      #1;
      check("t6_irq", 32'(irq), 0);
      check("t6_vector", 32'(vector), 0);
      check("t6_vv", 32'(vec_valid), 0);
      check("t6_pend", 32'(pending), 0);
      check("t6_isr", 32'(in_service), 0);
      check("t6_mask", 32'(mask_out), 0);
      model_reset();
      intr = 8'h08;
      @(posedge clk);
      @(negedge clk); reset = 1'b1;
      step(8'h08, 0, 0, 0, 0);
      check("t6_edge_after_rst", 32'(pending), 32'h08);
      step(8'h08, 0, 0, 0, 0);
      step(8'h00, 0, 0, 1, 0);
      check("t6_vec3", 32'(vector), 32'h3CC);
      step(8'h00, 0, 0, 0, 1);

      // random traffic
      cur_intr = '0;
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 2) == 0) cur_intr = cur_intr ^ 8'($urandom & $urandom);
         step(cur_intr,
              ($urandom_range(0, 19) == 0), 8'($urandom & $urandom),
              m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 4) == 0));
      end
      step(8'h00, 0, 0, 0, 0);

      check("sb_drained", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
